// File: rtl/salsa20_pkg.sv
// Salsa20 shared types: word/state types, FSM encoding, quarter-round
// rotate amounts, column/row index tables and state pack/unpack helpers.
package salsa20_pkg;

   typedef logic [31:0] word_t;
   typedef word_t [15:0] state_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ROUND,
      S_ADD,
      S_DONE
   } fsm_t;

   localparam int unsigned ROT_B = 7;
   localparam int unsigned ROT_C = 9;
   localparam int unsigned ROT_D = 13;
   localparam int unsigned ROT_A = 18;

   // Each row lists the (a,b,c,d) word indices for one quarter round
   localparam logic [3:0] COL_IDX [4][4] = '{
      '{4'd0,  4'd4,  4'd8,  4'd12},
      '{4'd5,  4'd9,  4'd13, 4'd1},
      '{4'd10, 4'd14, 4'd2,  4'd6},
      '{4'd15, 4'd3,  4'd7,  4'd11}
   };

   localparam logic [3:0] ROW_IDX [4][4] = '{
      '{4'd0,  4'd1,  4'd2,  4'd3},
      '{4'd5,  4'd6,  4'd7,  4'd4},
      '{4'd10, 4'd11, 4'd8,  4'd9},
      '{4'd15, 4'd12, 4'd13, 4'd14}
   };

   function automatic word_t rotl(input word_t x, input int unsigned n);
      return (x << n) | (x >> (32 - n));
   endfunction

   // state_t word i occupies bits [32*i+31:32*i], matching the port packing
   function automatic state_t unpack(input logic [511:0] v);
      return state_t'(v);
   endfunction

   function automatic logic [511:0] pack(input state_t s);
      return 512'(s);
   endfunction

endpackage

// File: rtl/quarter_round.sv
// Combinational Salsa20 quarter round on four 32-bit words.
// Ports: i_a..i_d input words, o_a..o_d output words.
module quarter_round
   import salsa20_pkg::*;
(
   input  word_t i_a,
   input  word_t i_b,
   input  word_t i_c,
   input  word_t i_d,
   output word_t o_a,
   output word_t o_b,
   output word_t o_c,
   output word_t o_d
);

   word_t w_a;
   word_t w_b;
   word_t w_c;
   word_t w_d;

   assign w_b = i_b ^ rotl(i_a + i_d, ROT_B);
   assign w_c = i_c ^ rotl(w_b + i_a, ROT_C);
   assign w_d = i_d ^ rotl(w_c + w_b, ROT_D);
   assign w_a = i_a ^ rotl(w_d + w_c, ROT_A);

   assign o_a = w_a;
   assign o_b = w_b;
   assign o_c = w_c;
   assign o_d = w_d;

endmodule

// File: rtl/salsa20_round.sv
// One Salsa20 round: four parallel quarter rounds, column or row selected.
// Ports: i_state in, i_row_sel (0 column, 1 row), o_state out.
module salsa20_round
   import salsa20_pkg::*;
(
   input  state_t i_state,
   input  logic   i_row_sel,
   output state_t o_state
);

   logic [3:0] w_idx [4][4];
   word_t      w_q   [4][4];

   for (genvar q = 0; q < 4; q++) begin : g_qr
      for (genvar k = 0; k < 4; k++) begin : g_idx
         assign w_idx[q][k] = i_row_sel ? ROW_IDX[q][k] : COL_IDX[q][k];
      end

      quarter_round u_qr (
         .i_a (i_state[w_idx[q][0]]),
         .i_b (i_state[w_idx[q][1]]),
         .i_c (i_state[w_idx[q][2]]),
         .i_d (i_state[w_idx[q][3]]),
         .o_a (w_q[q][0]),
         .o_b (w_q[q][1]),
         .o_c (w_q[q][2]),
         .o_d (w_q[q][3])
      );
   end

   // Both index tables cover all 16 words exactly once
   always_comb begin
      o_state = i_state;
      for (int q = 0; q < 4; q++) begin
         for (int k = 0; k < 4; k++) begin
            o_state[w_idx[q][k]] = w_q[q][k];
         end
      end
   end

endmodule

// File: rtl/salsa20_core.sv
// Iterative Salsa20 block core, one round per clock. Optional feed-forward
// add of the input state when SALSA20_FEEDFORWARD_EN is defined.
// Ports: clk, rst_n (async low), in_valid/in_ready/in_state (512b),
//        out_valid/out_ready/out_state (512b), busy (ROUND or ADD).
module salsa20_core
   import salsa20_pkg::*;
#(
   parameter int ROUNDS = 20,
   parameter int CTR_W  = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [511:0] in_state,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [511:0] out_state,
   output logic         busy
);

   localparam logic [CTR_W-1:0] LAST = CTR_W'(ROUNDS - 1);

   fsm_t             r_state;
   fsm_t             w_next;
   state_t           r_work;
   state_t           r_out;
   logic [CTR_W-1:0] r_ctr;
   logic             r_out_valid;
   state_t           w_round;
   state_t           w_result;

`ifdef SALSA20_FEEDFORWARD_EN
   state_t           r_save;
`endif

   salsa20_round u_round (
      .i_state   (r_work),
      .i_row_sel (r_ctr[0]),
      .o_state   (w_round)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (in_valid)        w_next = S_ROUND;
         S_ROUND: if (r_ctr == LAST)   w_next = S_ADD;
         S_ADD:                        w_next = S_DONE;
         S_DONE:  if (out_ready)       w_next = S_IDLE;
         default:                      w_next = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready = (r_state == S_IDLE);
      busy     = (r_state == S_ROUND) || (r_state == S_ADD);
   end

   always_comb begin
`ifdef SALSA20_FEEDFORWARD_EN
      for (int i = 0; i < 16; i++) begin
         w_result[i] = r_work[i] + r_save[i];
      end
`else
      w_result = r_work;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_work      <= '0;
         r_out       <= '0;
         r_ctr       <= '0;
         r_out_valid <= 1'b0;
`ifdef SALSA20_FEEDFORWARD_EN
         r_save      <= '0;
`endif
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_work <= unpack(in_state);
                  r_ctr  <= '0;
`ifdef SALSA20_FEEDFORWARD_EN
                  r_save <= unpack(in_state);
`endif
               end
            end
            S_ROUND: begin
               r_work <= w_round;
               r_ctr  <= r_ctr + CTR_W'(1);
            end
            S_ADD: begin
               r_out       <= w_result;
               r_out_valid <= 1'b1;
            end
            S_DONE: begin
               if (out_ready) r_out_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign out_valid = r_out_valid;
   assign out_state = pack(r_out);

endmodule

// File: tb/tb_salsa20_core.sv
// Directed bench for salsa20_core (ROUNDS=20) with a reference model.
// Follows SALSA20_FEEDFORWARD_EN the same way the core does.
module tb_salsa20_core;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [511:0] in_state;
   logic         out_valid;
   logic         out_ready;
   logic [511:0] out_state;
   logic         busy;

   int nchk  = 0;
   int nfail = 0;

   always #5 clk = ~clk;

   salsa20_core #(.ROUNDS(20), .CTR_W(5)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_state  (in_state),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_state (out_state),
      .busy      (busy)
   );

   task automatic chk(input string tag, input logic [511:0] obs,
                      input logic [511:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rl(input logic [31:0] x, input int n);
      return (x << n) | (x >> (32 - n));
   endfunction

   // Column round; quarter round q starts at word 5q, then steps of 4
   function automatic logic [511:0] colround(input logic [511:0] s);
      logic [31:0] y [16];
      int a, b, c, d;
      for (int i = 0; i < 16; i++) y[i] = s[32*i +: 32];
      for (int q = 0; q < 4; q++) begin
         a = 5 * q;
         b = (a + 4) % 16;
         c = (a + 8) % 16;
         d = (a + 12) % 16;
         y[b] = y[b] ^ rl(y[a] + y[d], 7);
         y[c] = y[c] ^ rl(y[b] + y[a], 9);
         y[d] = y[d] ^ rl(y[c] + y[b], 13);
         y[a] = y[a] ^ rl(y[d] + y[c], 18);
      end
      for (int i = 0; i < 16; i++) colround[32*i +: 32] = y[i];
   endfunction

   function automatic logic [511:0] transpose(input logic [511:0] s);
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            transpose[32*(4*r+c) +: 32] = s[32*(4*c+r) +: 32];
   endfunction

   function automatic logic [511:0] salsa_ref(input logic [511:0] in,
                                              input int rounds);
      logic [511:0] s;
      s = in;
      for (int r = 0; r < rounds; r++) begin
         if (r % 2 == 0) s = colround(s);
         else            s = transpose(colround(transpose(s)));
      end
`ifdef SALSA20_FEEDFORWARD_EN
      for (int i = 0; i < 16; i++)
         s[32*i +: 32] = s[32*i +: 32] + in[32*i +: 32];
`endif
      return s;
   endfunction

   task automatic run_block(input logic [511:0] st, input string tag,
                            input bit probe, input logic [511:0] pexp,
                            input int stall);
      int n;
      logic [511:0] snap;
      @(negedge clk);
      chk({tag, "_rdy"}, 512'(in_ready), 512'(1));
      in_state = st;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      n = 0;
      @(negedge clk);
      chk({tag, "_busy"}, 512'({busy, in_ready}), 512'(2'b10));
      if (probe) begin
         @(posedge clk);
         n++;
         #1 chk({tag, "_probe"}, 512'(dut.r_work), pexp);
      end
      do begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end while (!out_valid && n < 100);
      chk({tag, "_lat"}, 512'(n), 512'(21));
      chk({tag, "_out"}, out_state, salsa_ref(st, 20));
      if (stall > 0) begin
         snap = out_state;
         in_valid = 1'b1;
         for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk({tag, "_stl_v"}, 512'({out_valid, in_ready}), 512'(2'b10));
            chk({tag, "_stl_d"}, out_state, snap);
         end
         in_valid = 1'b0;
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      chk({tag, "_vld0"}, 512'({out_valid, in_ready}), 512'(2'b01));
   endtask

   logic [511:0] v_zero, v_probe, p_exp, v_a, v_b, v_ones;
   logic [511:0] blk [3];
   int acc_cyc [3];
   int nacc, nout, cyc;
   bit acc;

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_state  = '0;

      v_zero  = '0;
      v_probe = '0;
      v_probe[0*32 +: 32]  = 32'd1;
      v_probe[4*32 +: 32]  = 32'd2;
      v_probe[8*32 +: 32]  = 32'd3;
      v_probe[12*32 +: 32] = 32'd4;
      p_exp = '0;
      p_exp[0*32 +: 32]  = 32'h981E8457;
      p_exp[4*32 +: 32]  = 32'h00000282;
      p_exp[8*32 +: 32]  = 32'h00050603;
      p_exp[12*32 +: 32] = 32'hA110A004;
      for (int i = 0; i < 16; i++) begin
         v_a[32*i +: 32] = 32'h9E3779B9 * (i + 1);
         v_b[32*i +: 32] = 32'h01234567 ^ (32'h11111111 * i);
      end
      v_ones = '1;

      #12;
      chk("rst_vld", 512'(out_valid), 512'(0));
      chk("rst_busy", 512'(busy), 512'(0));
      chk("rst_out", out_state, 512'(0));
      chk("rst_ctr", 512'(dut.r_ctr), 512'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_rdy", 512'(in_ready), 512'(1));

      run_block(v_zero, "zero", 1'b0, '0, 0);
      chk("zero_abs", out_state, 512'(0));
      run_block(v_probe, "probe", 1'b1, p_exp, 0);
      run_block(v_a, "vecA", 1'b0, '0, 5);
      run_block(v_ones, "ones", 1'b0, '0, 0);

      blk[0] = v_b;
      blk[1] = v_probe;
      blk[2] = v_a;
      acc_cyc = '{0, 0, 0};
      nacc = 0;
      nout = 0;
      cyc  = 0;
      @(negedge clk);
      in_state  = blk[0];
      in_valid  = 1'b1;
      out_ready = 1'b1;
      while (nout < 3 && cyc < 200) begin
         if (out_valid) begin
            chk("strm_out", out_state, salsa_ref(blk[nout], 20));
            nout++;
         end
         acc = in_ready && in_valid;
         if (acc && nacc < 3) acc_cyc[nacc] = cyc;
         @(posedge clk);
         #1;
         cyc++;
         if (acc) begin
            nacc++;
            if (nacc < 3) in_state = blk[nacc];
            else          in_valid = 1'b0;
         end
         @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk("strm_cnt", 512'({nacc, nout}), 512'({32'd3, 32'd3}));
      chk("strm_gap1", 512'(acc_cyc[1] - acc_cyc[0]), 512'(23));
      chk("strm_gap2", 512'(acc_cyc[2] - acc_cyc[1]), 512'(23));

      @(negedge clk);
      in_state = v_b;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_vld", 512'(out_valid), 512'(0));
      chk("arst_busy", 512'({busy, in_ready}), 512'(2'b01));
      chk("arst_out", out_state, 512'(0));
      chk("arst_ctr", 512'(dut.r_ctr), 512'(0));
      @(negedge clk);
      rst_n = 1'b1;
      run_block(v_a, "post", 1'b0, '0, 0);

      $display("%0d/%0d checks passed", nchk - nfail, nchk);
      $finish;
   end

endmodule
